// File: rtl/mulmod4591_arbiter.sv
// Round-robin front end for a shared mod-4591 multiplier.
// Issues one product per cycle and routes reduced results back by requester ID.
module mulmod4591_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int P_WIDTH = 16,
    parameter int LAT     = 3
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [N_REQ-1:0]           Req,
    input  logic [N_REQ*P_WIDTH-1:0]   ReqA,
    input  logic [N_REQ*P_WIDTH-1:0]   ReqB,
    input  logic                       Hold,
    output logic [N_REQ-1:0]           Gnt,
    output logic [2*P_WIDTH-1:0]       MulIn,
    output logic                       MulValid,
    input  logic [P_WIDTH-1:0]         MulOut,
    output logic [N_REQ-1:0]           RspValid,
    output logic [P_WIDTH-1:0]         RspData,
    output logic                       ErrOperand,
    output logic                       Busy
);

    localparam logic [P_WIDTH-1:0] MODULUS = P_WIDTH'(4591);
    localparam logic [ID_W-1:0]    PTR_RST = ID_W'(N_REQ - 1);

    // Round-robin pointer: last requester that completed a transfer
    logic [ID_W-1:0]          r_ptr;

    // Issue stage
    logic                     r_mul_valid;
    logic [2*P_WIDTH-1:0]     r_mul_in;
    logic [ID_W-1:0]          r_issue_id;
    logic                     r_err;

    // Tag pipeline mirroring the external reduction latency
    logic [LAT-1:0]           r_tag_v;
    logic [ID_W-1:0]          r_tag_id [LAT];

    // Response register
    logic [N_REQ-1:0]         r_rsp_valid;
    logic [P_WIDTH-1:0]       r_rsp_data;

    // Arbitration and operand selection
    logic [ID_W-1:0]          w_cand;
    logic [ID_W-1:0]          w_win;
    logic                     w_found;
    logic                     w_accept;
    logic [P_WIDTH-1:0]       w_a;
    logic [P_WIDTH-1:0]       w_b;
    logic [2*P_WIDTH-1:0]     w_prod;
    logic                     w_bad;

    // Find the first asserted request after the pointer, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && Req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // One-hot grant, suppressed by Hold and while Reset is high
    always_comb begin
        Gnt = '0;
        if (w_found && !Hold && !Reset) begin
            Gnt[w_win] = 1'b1;
        end
    end

    assign w_accept = |(Req & Gnt);
    assign w_a      = ReqA[w_win*P_WIDTH +: P_WIDTH];
    assign w_b      = ReqB[w_win*P_WIDTH +: P_WIDTH];
    assign w_prod   = {{P_WIDTH{1'b0}}, w_a} * {{P_WIDTH{1'b0}}, w_b};
    assign w_bad    = (w_a >= MODULUS) || (w_b >= MODULUS);

    // Issue the winner's full product; pointer moves only on acceptance
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_mul_valid <= 1'b0;
            r_mul_in    <= '0;
            r_issue_id  <= '0;
            r_ptr       <= PTR_RST;
            r_err       <= 1'b0;
        end else begin
            r_mul_valid <= w_accept;
            if (w_accept) begin
                r_mul_in   <= w_prod;
                r_issue_id <= w_win;
                r_ptr      <= w_win;
                if (w_bad) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Carry {valid, ID} alongside the external reduction pipeline
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tag_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_mul_valid;
            r_tag_id[0] <= r_issue_id;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Capture the reduced result and strobe its owner for one cycle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_tag_v[LAT-1]) begin
                r_rsp_valid[r_tag_id[LAT-1]] <= 1'b1;
                r_rsp_data                   <= MulOut;
            end
        end
    end

    assign MulIn      = r_mul_in;
    assign MulValid   = r_mul_valid;
    assign RspValid   = r_rsp_valid;
    assign RspData    = r_rsp_data;
    assign ErrOperand = r_err;
    assign Busy       = r_mul_valid | (|r_tag_v) | (|r_rsp_valid);

endmodule

// File: tb/tb_mulmod4591_arbiter.sv
// Directed bench for mulmod4591_arbiter.
// Models the external reduction stage as a 3-cycle mod-4591 pipeline.
module tb_mulmod4591_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [N-1:0]     Req;
    logic [N*W-1:0]   ReqA;
    logic [N*W-1:0]   ReqB;
    logic             Hold;
    logic [N-1:0]     Gnt;
    logic [2*W-1:0]   MulIn;
    logic             MulValid;
    logic [W-1:0]     MulOut;
    logic [N-1:0]     RspValid;
    logic [W-1:0]     RspData;
    logic             ErrOperand;
    logic             Busy;

    int n_tot = 0;
    int n_bad = 0;

    logic [W-1:0] r_red [3];

    mulmod4591_arbiter #(
        .N_REQ(N), .ID_W(2), .P_WIDTH(W), .LAT(3)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .ReqA(ReqA), .ReqB(ReqB),
        .Hold(Hold), .Gnt(Gnt), .MulIn(MulIn), .MulValid(MulValid),
        .MulOut(MulOut), .RspValid(RspValid), .RspData(RspData),
        .ErrOperand(ErrOperand), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // External reduction pipeline: MulOut valid LAT cycles after MulValid
    always @(posedge Clk) begin
        r_red[0] <= W'(MulIn % 32'd4591);
        r_red[1] <= r_red[0];
        r_red[2] <= r_red[1];
    end
    assign MulOut = r_red[2];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic setop(input int i, input int a, input int b);
        ReqA[i*W +: W] = W'(a);
        ReqB[i*W +: W] = W'(b);
    endtask

    task automatic do_reset();
        tick();
        Req   = '0;
        Hold  = 1'b0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Single isolated transfer: grant, issue, response at +5, idle at +6
    task automatic one_op(input int id, input int a, input int b,
                          input logic [31:0] prod, input logic [15:0] res);
        logic [N-1:0] oh;
        oh = 4'b0001 << id;
        tick();
        Req = oh;
        setop(id, a, b);
        #1;
        chk("op_gnt", 64'(Gnt), 64'(oh));
        tick();
        Req = '0;
        chk("op_mv", 64'(MulValid), 64'd1);
        chk("op_mulin", 64'(MulIn), 64'(prod));
        chk("op_busy", 64'(Busy), 64'd1);
        tick();
        tick();
        tick();
        chk("op_early", 64'(RspValid), 64'd0);
        tick();
        chk("op_rspv", 64'(RspValid), 64'(oh));
        chk("op_rspd", 64'(RspData), 64'(res));
        tick();
        chk("op_idle", 64'(Busy), 64'd0);
        chk("op_rsp0", 64'(RspValid), 64'd0);
    endtask

    logic [15:0] fprod [4];
    logic [15:0] bsq   [3];

    initial begin
        fprod = '{16'd200, 16'd231, 16'd264, 16'd299};
        bsq   = '{16'd1, 16'd4, 16'd9};
        Reset = 1'b1;
        Req   = '0;
        Hold  = 1'b0;
        ReqA  = '0;
        ReqB  = '0;

        // Reset state, with requests present
        tick();
        tick();
        Req = 4'b1111;
        #1;
        chk("rst_gnt", 64'(Gnt), 64'd0);
        chk("rst_mv", 64'(MulValid), 64'd0);
        chk("rst_mulin", 64'(MulIn), 64'd0);
        chk("rst_rspv", 64'(RspValid), 64'd0);
        chk("rst_rspd", 64'(RspData), 64'd0);
        chk("rst_err", 64'(ErrOperand), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        Req   = '0;
        Reset = 1'b0;

        // Single ops and modulus wrap
        one_op(1, 3, 5, 32'd15, 16'd15);
        one_op(0, 4590, 4590, 32'd21068100, 16'd1);
        one_op(2, 2, 2296, 32'd4592, 16'd1);

        // Fairness: all four hold Req for 8 cycles
        do_reset();
        for (int i = 0; i < N; i++) setop(i, i + 10, i + 20);
        for (int c = 0; c < 13; c++) begin
            tick();
            Req = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8)
                chk("rr_gnt", 64'(Gnt), 64'(4'b0001 << (c % 4)));
            if (c >= 1 && c <= 8)
                chk("rr_mulin", 64'(MulIn), 64'(fprod[(c-1)%4]));
            if (c >= 5) begin
                chk("rr_rspv", 64'(RspValid), 64'(4'b0001 << ((c-5) % 4)));
                chk("rr_rspd", 64'(RspData), 64'(fprod[(c-5)%4]));
            end
        end

        // Back-to-back from requester 3
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c < 3) begin
                Req = 4'b1000;
                setop(3, c + 1, c + 1);
            end else begin
                Req = '0;
            end
            #1;
            if (c < 3) chk("b2b_gnt", 64'(Gnt), 64'(4'b1000));
            if (c == 4) chk("b2b_early", 64'(RspValid), 64'd0);
            if (c >= 5 && c < 8) begin
                chk("b2b_rspv", 64'(RspValid), 64'(4'b1000));
                chk("b2b_rspd", 64'(RspData), 64'(bsq[c-5]));
            end
            if (c == 8) chk("b2b_done", 64'(RspValid), 64'd0);
        end

        // Hold: two ops go out, then grants stop while they drain
        setop(0, 7, 8);
        setop(1, 9, 9);
        setop(2, 4, 4);
        setop(3, 6, 6);
        for (int c = 0; c < 9; c++) begin
            tick();
            Req  = (c < 8) ? 4'b1111 : 4'b0000;
            Hold = (c >= 2 && c < 8);
            #1;
            if (c < 2) chk("hold_gnt", 64'(Gnt), 64'(4'b0001 << c));
            else if (c < 8) chk("hold_nognt", 64'(Gnt), 64'd0);
            if (c == 5) begin
                chk("hold_rspv0", 64'(RspValid), 64'(4'b0001));
                chk("hold_rspd0", 64'(RspData), 64'd56);
            end
            if (c == 6) begin
                chk("hold_rspv1", 64'(RspValid), 64'(4'b0010));
                chk("hold_rspd1", 64'(RspData), 64'd81);
            end
            if (c == 7) chk("hold_rspv2", 64'(RspValid), 64'd0);
        end

        // Reset with two ops in flight
        setop(2, 5, 6);
        for (int c = 0; c < 2; c++) begin
            tick();
            Req = 4'b0100;
            #1;
            chk("rm_gnt", 64'(Gnt), 64'(4'b0100));
        end
        tick();
        Req   = 4'b1111;
        Reset = 1'b1;
        #1;
        chk("rm_gnt_rst", 64'(Gnt), 64'd0);
        chk("rm_busy_rst", 64'(Busy), 64'd0);
        chk("rm_mv_rst", 64'(MulValid), 64'd0);
        tick();
        Req   = '0;
        Reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rm_rspv", 64'(RspValid), 64'd0);
            chk("rm_busy", 64'(Busy), 64'd0);
        end

        // Out-of-range operand sets the sticky error
        tick();
        Req = 4'b0001;
        setop(0, 4591, 1);
        #1;
        chk("err_gnt", 64'(Gnt), 64'(4'b0001));
        chk("err_pre", 64'(ErrOperand), 64'd0);
        tick();
        Req = '0;
        chk("err_set", 64'(ErrOperand), 64'd1);
        repeat (5) tick();
        chk("err_hold", 64'(ErrOperand), 64'd1);
        do_reset();
        #1;
        chk("err_clr", 64'(ErrOperand), 64'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
